// File: rtl/arb_pkg.sv
// Shared types and helpers for the parametrised round-robin arbiter.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  // Widest request vector the index helper accepts.
  localparam int ARB_MAX_REQ = 64;

  // Binary index of a one-hot (or zero) vector; zero maps to 0.
  function automatic int unsigned onehot_to_bin(input logic [ARB_MAX_REQ-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin winner selection: first set request at or after ptr, wrapping.
module rr_priority_select #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] winner,
  output logic             any_req
);

  logic [N_REQ-1:0]   mask;
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] iso;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (ID_W'(i) >= ptr);
    end
  end

  // Lower half holds requests at/above ptr, upper half the wrapped-around copy,
  // so isolating the lowest set bit yields the cyclic first requester.
  assign dbl     = {req, req & mask};
  assign iso     = dbl & (-dbl);
  assign winner  = iso[N_REQ-1:0] | iso[2*N_REQ-1:N_REQ];
  assign any_req = |req;

endmodule

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with registered one-hot grant held until ack,
// request drop or hold timeout; re-arbitrates on release with no idle gap.
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             timeout
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_e       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [ID_W-1:0]  arb_ptr;
  logic [ID_W-1:0]  next_ptr;
  logic [N_REQ-1:0] winner;
  logic [ID_W-1:0]  winner_id;
  logic             any_req;
  logic             holder_req;
  logic             to_hit;
  logic             rel;

  // grant_id always names the holder while BUSY.
  assign holder_req = req[grant_id];
  assign to_hit     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign rel        = ack || !holder_req || to_hit;
  assign next_ptr   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign arb_ptr    = (state == BUSY && rel) ? next_ptr : ptr;
  assign winner_id  = ID_W'(onehot_to_bin(ARB_MAX_REQ'(winner)));

  rr_priority_select #(.N_REQ(N_REQ)) u_select (
    .req     (req),
    .ptr     (arb_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (any_req) begin
            state       <= BUSY;
            grant       <= winner;
            grant_valid <= 1'b1;
            grant_id    <= winner_id;
            hold_cnt    <= '0;
          end
        end
        BUSY: begin
          if (rel) begin
            ptr      <= next_ptr;
            hold_cnt <= '0;
            // A forced release that coincides with ack or a drop counts as that.
            timeout  <= to_hit && !ack && holder_req;
            if (any_req) begin
              grant       <= winner;
              grant_valid <= 1'b1;
              grant_id    <= winner_id;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_id    <= '0;
            end
          end else begin
            timeout <= 1'b0;
            if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Randomised and directed bench for rr_arbiter_param against a cycle-level reference model.
module tb_rr_arbiter_param;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int ID_W     = $clog2(N);
  localparam int EW       = N + ID_W + 2;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req;
  logic          ack;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [ID_W-1:0] grant_id;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model: holder index (-1 idle), priority start, cycles the
  // current grant has been visible, and the pending timeout pulse.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_age    = 0;
  bit m_to     = 0;

  rr_arbiter_param #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_age    = 0;
    m_to     = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic a);
    bit forced;
    bit released;
    m_to = 0;
    if (m_holder < 0) begin
      m_holder = pick(r, m_ptr);
      m_age    = 1;
    end else begin
      forced   = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
      released = a || !r[m_holder] || forced;
      if (released) begin
        m_to     = forced && !a && r[m_holder];
        m_ptr    = (m_holder + 1) % N;
        m_holder = pick(r, m_ptr);
        m_age    = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  function automatic logic [EW-1:0] model_out();
    logic [N-1:0]    g;
    logic [ID_W-1:0] id;
    g  = '0;
    id = '0;
    if (m_holder >= 0) begin
      g[m_holder] = 1'b1;
      id = ID_W'(m_holder);
    end
    return {m_to, (m_holder >= 0), id, g};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] r, input logic a);
    @(negedge clock);
    req = r;
    ack = a;
    model_step(r, a);
    exp_q.push_back(model_out());
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (grant !== '0 || grant_valid !== 1'b0 || grant_id !== '0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s: got grant=%b valid=%b id=%0d timeout=%b, need all zero",
               tag, grant, grant_valid, grant_id, timeout);
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_zero(tag);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [EW-1:0] e;
    logic [N-1:0]  eg;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      eg = e[N-1:0];
      checks++;
      if (grant !== eg || grant_id !== e[N+ID_W-1:N] || grant_valid !== e[N+ID_W] ||
          timeout !== e[N+ID_W+1]) begin
        errors++;
        $display("FAIL outputs @%0t: got grant=%b id=%0d valid=%b timeout=%b, need grant=%b id=%0d valid=%b timeout=%b",
                 $time, grant, grant_id, grant_valid, timeout,
                 eg, e[N+ID_W-1:N], e[N+ID_W], e[N+ID_W+1]);
      end
    end
    checks++;
    if (!$onehot0(grant) || (grant == '0 && grant_id != '0) ||
        (grant != '0 && grant[grant_id] !== 1'b1) || (grant_valid !== (|grant))) begin
      errors++;
      $display("FAIL onehot @%0t: got grant=%b id=%0d valid=%b, need one-hot/zero grant consistent with id and valid",
               $time, grant, grant_id, grant_valid);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    req   = '0;
    ack   = 1'b0;
    #1 check_zero("reset_state");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Idle with no requests.
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);

    // All requesting, ack every third cycle: rotation 0,1,2,3,0.
    for (int i = 0; i < 15; i++) step(4'b1111, (i % 3) == 2);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Lone requester holds past MAX_HOLD: timeout and immediate re-grant.
    for (int i = 0; i < 20; i++) step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);

    // Two requesters timing out, then ack landing on the timeout cycle.
    reset_pulse("reset_before_0101");
    for (int i = 0; i < 40; i++)
      step(4'b0101, (i >= 20) && (m_holder >= 0) && (m_age == MAX_HOLD));
    step(4'b0000, 1'b0);

    // Holder 3 drops its request with 0 waiting; then no preemption by 1.
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    step(4'b0000, 1'b0);

    // Reset in the middle of a grant, then pointer back at 0.
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    reset_pulse("reset_mid_grant");
    for (int i = 0; i < 3; i++) step(4'b1100, 1'b0);
    step(4'b1100, 1'b1);
    step(4'b0000, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) == 0));

    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
    @(negedge clock);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised N-way round-robin arbiter; successor to the fixed 4-way ack-rotated arbiter.
- Registered one-hot grant, held until release.
- Release occurs on ack, on the holder dropping its request, or on a hold timeout.
- Sits between N bus/resource requesters and a shared resource.
- Also reports the winner's index and a timeout pulse for the performance/debug counters.

Parameters:
N_REQ, 4, number of requesters (>= 2)
MAX_HOLD, 16, max cycles a grant may be held before forced release; 0 disables timeout
ID_W, $clog2(N_REQ), width of grant_id (derived, not overridden)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  request vector, level-sensitive, bit i = requester i
ack  input  1  current holder finished; valid only while grant_valid=1
grant  output  N_REQ  registered one-hot grant, all-zero when idle
grant_valid  output  1  OR of grant, registered
grant_id  output  ID_W  binary index of granted requester; 0 when idle
timeout  output  1  one-cycle pulse in the cycle after a forced release

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset). All state is reset asynchronously, and reset is released synchronously by the surrounding logic.
- Reset values:
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - Priority pointer ptr=0 (req[0] highest).
  - hold_cnt=0, state=IDLE.
- State machine: two states, IDLE and BUSY.
- IDLE:
  - If req!=0, the winner is the first set bit searching cyclically from ptr upward (ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - Next cycle: grant[winner]=1, grant_id=winner, grant_valid=1, hold_cnt=0, state goes to BUSY.
  - Latency from req to grant is 1 cycle.
  - If req==0, stay in IDLE with outputs 0.
- BUSY, holder h:
  - Release occurs if any of the following holds in the current cycle:
    - (a) ack=1;
    - (b) req[h]=0;
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1, and the grant is unchanged.
- On release:
  - ptr <= (h+1) mod N_REQ.
  - Re-arbitrate in the same cycle using the new pointer and the current req. This gives back-to-back grants with no idle cycle.
  - The new winner's grant appears next cycle, hold_cnt=0, state stays BUSY.
  - If req has no bits set (h's bit included), go to IDLE and clear grant next cycle.
  - h is eligible again, but at lowest priority. If h is the only requester it is re-granted immediately.
- timeout pulses 1 for one cycle, aligned with the new grant, only when release cause (c) applied and neither (a) nor (b) did.
- Simultaneous ack and timeout: the release is treated as an ack, so timeout stays 0.
- ack while in IDLE is ignored, with no pointer change.
- Changes on non-holder req bits never preempt the current holder.
- grant must be one-hot or zero in every cycle. Bench assertion: $onehot0(grant), and grant_id matches the position of the set bit.
- Reset asserted mid-grant: all outputs clear immediately (asynchronous) and ptr returns to 0.
- Pointer wrap: after h=N_REQ-1 releases, ptr=0.

Decomposition:
- Shared package arb_pkg:
  - typedef enum logic {IDLE, BUSY} arb_state_e;
  - helper function onehot_to_bin.
- One combinational sub-module, rr_priority_select #(N_REQ):
  - Inputs: req, ptr.
  - Outputs: one-hot winner and any_req.
  - Implemented as a double-width masked priority encoder.
- Top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan (N_REQ=4, MAX_HOLD=8):
- Reset, then req=4'b0000 -> grant=0, grant_valid=0, grant_id=0, timeout=0 for 10 cycles.
- req=4'b1111 held, ack pulsed every 3rd cycle -> grants rotate 0001,0010,0100,1000,0001. Each change is 1 cycle after ack, with no idle gap.
- req=4'b0010 held, no ack -> grant=0010 for 8 cycles, then re-granted 0010. timeout=1 for exactly one cycle; ptr wraps to 2 internally.
- req=4'b0101 and no ack; holder 0 times out -> grant=0100, timeout=1. Then ack on the same cycle as the timeout condition -> timeout stays 0.
- Holder 3 drops req[3] while req=4'b1001 -> next grant=0001 (ptr wrapped to 0). Assert req[1] while 0 holds -> no preemption.
- Reset asserted while grant=0100 -> grant=0 within the same cycle. After release, req=4'b1100 -> grant=0100 (ptr back to 0).
